match_controller: RTL
=====================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 6: comparator pipeline drain cycles after end of frame.
REQ-002 SHALL have parameter CNT_W, default 16: width of the frame word counter.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 n_rst  input  1  reset, synchronous, active-low.
REQ-005 cfg_wr  input  1  rule-table write strobe.
REQ-006 cfg_sel  input  2  rule index 0-3 to write.
REQ-007 cfg_addr  input  32  match pattern for the selected rule.
REQ-008 cfg_en  input  1  enable bit for the selected rule.
REQ-009 rx_valid  input  1  rx_data, rx_sof and rx_eof are valid this cycle.
REQ-010 rx_sof / rx_eof  input  1 each  first / last word of a frame; qualified by rx_valid.
REQ-011 rx_data  input  32  frame word.
REQ-012 comp_clear  output  1  clear to the shared comparator.
REQ-013 comp_addr  output  32  pattern presented to the comparator.
REQ-014 comp_data  output  32  word stream to the comparator.
REQ-015 comp_match  input  1  comparator match flag.
REQ-016 verdict_valid  output  1; verdict_ready  input  1  result handshake.
REQ-017 verdict_hit  output  1; verdict_rule  output  2; verdict_words  output  CNT_W; verdict_trunc  output  1  frame result fields.
REQ-018 drop_cnt  output  8  frames not scanned, saturating; busy  output  1  state is not IDLE.

Function
REQ-019 SHALL hold a 4-entry rule table of {enable, addr[31:0]}; a cfg_wr updates entry cfg_sel on that clock edge, and the write is legal in any state.
REQ-020 SHALL implement the states IDLE, SCAN, FLUSH and REPORT.
REQ-021 IDLE: comp_clear=1 and comp_data=0; on rx_valid&rx_sof with at least one rule enabled, SHALL select a rule, latch its addr into comp_addr, set the word count to 1, clear hit/trunc, then go to SCAN.
REQ-022 Rule selection SHALL be round-robin: the first enabled index after last_rule, modulo 4, with last_rule updated to the chosen index.
REQ-023 IDLE with rx_valid&rx_sof and no rule enabled SHALL keep the state in IDLE and increment drop_cnt.
REQ-024 comp_addr SHALL stay constant from SOF until REPORT exits, so a cfg write mid-frame does not affect the current frame.
REQ-025 comp_data SHALL be registered: rx_data when rx_valid in IDLE (at SOF) or SCAN, otherwise 32'h0.
REQ-026 SCAN: comp_clear=0; each rx_valid SHALL increment the word count, saturating at all-ones.
REQ-027 The hit flag SHALL be sticky: set when comp_match=1 in SCAN or FLUSH, and cleared only at SOF acceptance.
REQ-028 SCAN with rx_valid&rx_eof SHALL load the flush counter with FLUSH_CYCLES and go to FLUSH.
REQ-029 SOF accepted with EOF in the same cycle (single-word frame) SHALL go IDLE->FLUSH directly with word count 1.
REQ-030 SCAN with rx_valid&rx_sof and no eof SHALL set trunc=1, not count that word, increment drop_cnt, and go to FLUSH.
REQ-031 FLUSH: the counter SHALL decrement each cycle, and the block SHALL go to REPORT when the counter is 1 on that edge, giving exactly FLUSH_CYCLES cycles in FLUSH.
REQ-032 REPORT: verdict_valid=1, with verdict fields stable until verdict_ready=1; on handshake SHALL go to IDLE.
REQ-033 verdict_valid SHALL be combinational from the state; verdict_ready in the first REPORT cycle completes the handshake in 1 cycle.
REQ-034 Each rx_sof seen in FLUSH or REPORT SHALL increment drop_cnt, and that frame's words SHALL be ignored.
REQ-035 drop_cnt SHALL saturate at 8'hFF.
REQ-036 busy SHALL be 1 in SCAN, FLUSH and REPORT.

Reset
REQ-037 n_rst=0 sampled on a clk edge SHALL set: state IDLE, all rules disabled with addr=0, last_rule=3, comp_clear=1, comp_addr=0, comp_data=0, verdict_valid=0, verdict_hit=0, verdict_rule=0, verdict_words=0, verdict_trunc=0, drop_cnt=0, busy=0.
REQ-038 Reset SHALL take priority over cfg_wr and the handshake in all states, aborting any frame in progress with no verdict issued.

Verification
REQ-039 Program rule0=32'hC0A80001 enabled; send a 4-word frame containing that value; hold verdict_ready=1 -> verdict_valid exactly 1 cycle, FLUSH_CYCLES+1 cycles after EOF; hit=1, rule=0, words=4, trunc=0.
REQ-040 Enable rules 0 and 2; send 3 non-matching frames -> verdict_rule sequence 0, 2, 0; hit=0 each.
REQ-041 Hold verdict_ready=0 for 10 cycles in REPORT and send SOF meanwhile -> fields stable; drop_cnt=1; that frame is never scanned.
REQ-042 SOF at word 3 of an open frame -> trunc=1, words=3, drop_cnt increments; rewrite rule mid-frame -> comp_addr unchanged until IDLE.
REQ-043 No rules enabled; send 300 frames -> drop_cnt=8'hFF, busy stays 0.
REQ-044 Assert n_rst=0 for one edge during SCAN -> next cycle every output equals its REQ-037 reset value.

Source files
------------

// File: rtl/match_controller_if.sv
// Signal bundle around the match controller: rule configuration, frame input,
// shared comparator port and the verdict result channel.
interface match_controller_if #(
   parameter int CNT_W = 16
);
   logic             cfg_wr;
   logic [1:0]       cfg_sel;
   logic [31:0]      cfg_addr;
   logic             cfg_en;
   logic             rx_valid;
   logic             rx_sof;
   logic             rx_eof;
   logic [31:0]      rx_data;
   logic             comp_clear;
   logic [31:0]      comp_addr;
   logic [31:0]      comp_data;
   logic             comp_match;
   logic             verdict_valid;
   logic             verdict_ready;
   logic             verdict_hit;
   logic [1:0]       verdict_rule;
   logic [CNT_W-1:0] verdict_words;
   logic             verdict_trunc;
   logic [7:0]       drop_cnt;
   logic             busy;

   // Verdict handshake: a result transfers on a rising edge where verdict_valid
   // and verdict_ready are both 1; while valid is high and ready is low every
   // verdict_* field holds its value. rx_* has no back-pressure: a word is
   // consumed on each edge where rx_valid is 1.
   modport master (
      output cfg_wr, cfg_sel, cfg_addr, cfg_en,
      output rx_valid, rx_sof, rx_eof, rx_data,
      input  comp_clear, comp_addr, comp_data,
      output comp_match,
      input  verdict_valid,
      output verdict_ready,
      input  verdict_hit, verdict_rule, verdict_words, verdict_trunc,
      input  drop_cnt, busy
   );

   modport slave (
      input  cfg_wr, cfg_sel, cfg_addr, cfg_en,
      input  rx_valid, rx_sof, rx_eof, rx_data,
      output comp_clear, comp_addr, comp_data,
      input  comp_match,
      output verdict_valid,
      input  verdict_ready,
      output verdict_hit, verdict_rule, verdict_words, verdict_trunc,
      output drop_cnt, busy
   );
endinterface

// File: rtl/match_controller.sv
// Frame scanner: picks an enabled rule round-robin per frame, streams the words
// to a shared comparator, drains its pipeline and reports a per-frame verdict.
module match_controller #(
   parameter int FLUSH_CYCLES = 6,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   match_controller_if.slave bus,
   output logic [1:0]        dbg_state
);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FLUSH  = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t           state;
   logic [3:0]       rule_en;
   logic [31:0]      rule_addr [4];
   logic [1:0]       last_rule;
   logic [1:0]       cur_rule;
   logic [1:0]       pick;
   logic [CNT_W-1:0] words;
   logic             hit;
   logic             trunc;
   logic             comp_clear;
   logic [31:0]      comp_addr;
   logic [31:0]      comp_data;
   logic [FW-1:0]    flush_cnt;
   logic [7:0]       drop_cnt;
   logic             sof_in;
   logic             any_en;
   logic             drop_inc;

   assign sof_in = bus.rx_valid & bus.rx_sof;
   assign any_en = |rule_en;

   // Nearest enabled index after last_rule wins; the wrap back to last_rule itself is the fallback.
   always_comb begin
      pick = last_rule;
      for (int i = 3; i >= 1; i--) begin
         if (rule_en[last_rule + 2'(i)]) begin
            pick = last_rule + 2'(i);
         end
      end
   end

   always_comb begin
      drop_inc = 1'b0;
      case (state)
         IDLE:    drop_inc = sof_in & ~any_en;
         SCAN:    drop_inc = sof_in & ~bus.rx_eof;
         default: drop_inc = sof_in;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         rule_en    <= '0;
         for (int i = 0; i < 4; i++) begin
            rule_addr[i] <= '0;
         end
         last_rule  <= 2'd3;
         cur_rule   <= 2'd0;
         words      <= '0;
         hit        <= 1'b0;
         trunc      <= 1'b0;
         comp_clear <= 1'b1;
         comp_addr  <= '0;
         comp_data  <= '0;
         flush_cnt  <= '0;
         drop_cnt   <= '0;
      end else begin
         if (bus.cfg_wr) begin
            rule_en[bus.cfg_sel]   <= bus.cfg_en;
            rule_addr[bus.cfg_sel] <= bus.cfg_addr;
         end
         if (drop_inc && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
         comp_data <= '0;
         case (state)
            IDLE: begin
               if (sof_in && any_en) begin
                  cur_rule   <= pick;
                  last_rule  <= pick;
                  comp_addr  <= rule_addr[pick];
                  comp_data  <= bus.rx_data;
                  comp_clear <= 1'b0;
                  words      <= CNT_W'(1);
                  hit        <= 1'b0;
                  trunc      <= 1'b0;
                  if (bus.rx_eof) begin
                     flush_cnt <= FW'(FLUSH_CYCLES);
                     state     <= FLUSH;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (bus.comp_match) begin
                  hit <= 1'b1;
               end
               if (bus.rx_valid) begin
                  comp_data <= bus.rx_data;
                  if (bus.rx_sof && !bus.rx_eof) begin
                     // A new frame cut this one short; the intruding word is not counted.
                     trunc     <= 1'b1;
                     flush_cnt <= FW'(FLUSH_CYCLES);
                     state     <= FLUSH;
                  end else begin
                     if (words != '1) begin
                        words <= words + CNT_W'(1);
                     end
                     if (bus.rx_eof) begin
                        flush_cnt <= FW'(FLUSH_CYCLES);
                        state     <= FLUSH;
                     end
                  end
               end
            end
            FLUSH: begin
               if (bus.comp_match) begin
                  hit <= 1'b1;
               end
               flush_cnt <= flush_cnt - FW'(1);
               if (flush_cnt == FW'(1)) begin
                  state <= REPORT;
               end
            end
            REPORT: begin
               if (bus.verdict_ready) begin
                  comp_clear <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.comp_clear    = comp_clear;
   assign bus.comp_addr     = comp_addr;
   assign bus.comp_data     = comp_data;
   assign bus.verdict_valid = (state == REPORT);
   assign bus.verdict_hit   = hit;
   assign bus.verdict_rule  = cur_rule;
   assign bus.verdict_words = words;
   assign bus.verdict_trunc = trunc;
   assign bus.drop_cnt      = drop_cnt;
   assign bus.busy          = (state != IDLE);
   assign dbg_state         = state;
endmodule
